// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared op-field constants and FSM state type for the load/store unit
package lsu_pkg;

  localparam int OP_STORE    = 3;
  localparam int OP_UNSIGNED = 2;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - little-endian lane extract/extend for loads and lane merge for stores
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [4:0]  shift;
  logic [31:0] lane_mask;
  logic [31:0] shifted;

  // Lane position and mask; a half lane is selected by addr[1] alone
  always_comb begin
    shift     = 5'd0;
    lane_mask = 32'hFFFF_FFFF;
    case (size)
      SIZE_BYTE: begin
        shift     = {addr_lo, 3'b000};
        lane_mask = 32'h0000_00FF << shift;
      end
      SIZE_HALF: begin
        shift     = {addr_lo[1], 4'b0000};
        lane_mask = 32'h0000_FFFF << shift;
      end
      default: begin
        shift     = 5'd0;
        lane_mask = 32'hFFFF_FFFF;
      end
    endcase
    shifted = word >> shift;
  end

  // Load result: right-align the lane, then sign- or zero-extend it
  always_comb begin
    load_data = 32'h0;
    case (size)
      SIZE_BYTE: load_data = is_unsigned ? {24'h0, shifted[7:0]}
                                         : {{24{shifted[7]}}, shifted[7:0]};
      SIZE_HALF: load_data = is_unsigned ? {16'h0, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
      SIZE_WORD: load_data = word;
      default:   load_data = 32'h0;
    endcase
  end

  // Store merge: replace only the addressed lane(s) of the captured word
  always_comb begin
    merged = (word & ~lane_mask) | ((wdata << shift) & lane_mask);
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - MEM-stage load/store FSM driving a word-addressed data memory
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int WORD_BITS  = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [3:0]            req_op,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_memwrite,
  output logic                  mem_memread,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  lsu_state_t            state_q, state_d;
  logic [3:0]            op_q;
  logic [WORD_BITS+1:0]  addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] word_q;
  logic                  err_q;
  logic                  req_err;
  logic                  accept;
  logic [DATA_WIDTH-1:0] word_addr;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] merged;

  assign accept    = req_valid & req_ready;
  assign word_addr = {{(DATA_WIDTH-WORD_BITS){1'b0}}, addr_q[WORD_BITS+1:2]};

  // Request error: reserved size, misalignment, or address beyond the memory
  always_comb begin
    req_err = 1'b0;
    if (req_op[1:0] == 2'b11) req_err = 1'b1;
    if (req_op[1:0] == SIZE_HALF && req_addr[0]) req_err = 1'b1;
    if (req_op[1:0] == SIZE_WORD && (req_addr[1:0] != 2'b00)) req_err = 1'b1;
    if (req_addr[DATA_WIDTH-1:WORD_BITS+2] != '0) req_err = 1'b1;
  end

  lsu_lane_align u_align (
    .word        (word_q),
    .addr_lo     (addr_q[1:0]),
    .size        (op_q[1:0]),
    .is_unsigned (op_q[OP_UNSIGNED]),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .merged      (merged)
  );

  // State register; reset abandons any access in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Request latch on accept, memory word capture at the end of READ
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= 4'h0;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= req_op;
        addr_q  <= req_addr[WORD_BITS+1:0];
        wdata_q <= req_wdata;
        err_q   <= req_err;
      end
      if (state_q == READ) word_q <= mem_read_data;
    end
  end

  // Next state and per-state outputs; strobes only ever come from READ/WRITE
  always_comb begin
    state_d        = state_q;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    mem_memread    = 1'b0;
    mem_memwrite   = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err)                                            state_d = RESP;
          else if (req_op[OP_STORE] && req_op[1:0] == SIZE_WORD)  state_d = WRITE;
          else                                                    state_d = READ;
        end
      end
      READ: begin
        mem_memread = 1'b1;
        mem_addr    = word_addr;
        state_d     = op_q[OP_STORE] ? WRITE : RESP;
      end
      WRITE: begin
        mem_memwrite   = 1'b1;
        mem_addr       = word_addr;
        mem_write_data = (op_q[1:0] == SIZE_WORD) ? wdata_q : merged;
        state_d        = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Response payload held steady from latched state while waiting in RESP
  assign resp_err   = (state_q == RESP) && err_q;
  assign resp_rdata = ((state_q == RESP) && !err_q && !op_q[OP_STORE]) ? load_data : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit with a data memory model
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_memwrite;
  logic        mem_memread;
  logic [31:0] mem_read_data;

  logic [31:0] dmem [256];
  logic        init_mem;

  int passed;
  int total;

  load_store_unit #(.WORD_BITS(8), .DATA_WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_memwrite   (mem_memwrite),
    .mem_memread    (mem_memread),
    .mem_read_data  (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_read_data = dmem[mem_addr[7:0]];

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) dmem[i] <= i;
    end else if (mem_memwrite) begin
      dmem[mem_addr[7:0]] <= mem_write_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic txn(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                     output int lat, output int nrd, output int nwr,
                     output logic [31:0] raddr, output logic [31:0] waddr,
                     output logic [31:0] wdat, output logic [31:0] rdata,
                     output logic err, output logic both);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1; nrd = 0; nwr = 0; both = 1'b0;
    raddr = '0; waddr = '0; wdat = '0;
    while (!resp_valid && lat < 10) begin
      if (mem_memread)  begin nrd++; raddr = mem_addr; end
      if (mem_memwrite) begin nwr++; waddr = mem_addr; wdat = mem_write_data; end
      if (mem_memread && mem_memwrite) both = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    rdata = resp_rdata;
    err   = resp_err;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    int lat, nrd, nwr;
    logic [31:0] raddr, waddr, wdat, rdata, hold_rdata;
    logic err, both;

    passed = 0; total = 0;
    rst = 1'b1; init_mem = 1'b1;
    req_valid = 1'b0; req_op = 4'h0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset_req_ready", {31'h0, req_ready}, 32'h1);
    chk("reset_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("reset_strobes", {30'h0, mem_memread, mem_memwrite}, 32'h0);
    chk("reset_mem_addr", mem_addr, 32'h0);
    init_mem = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    // 1. LW 0x18
    txn(4'b0010, 32'h18, 32'h0, lat, nrd, nwr, raddr, waddr, wdat, rdata, err, both);
    chk("lw_lat", lat, 2);
    chk("lw_nrd", nrd, 1);
    chk("lw_nwr", nwr, 0);
    chk("lw_raddr", raddr, 32'h6);
    chk("lw_rdata", rdata, 32'h6);
    chk("lw_err", {31'h0, err}, 32'h0);

    // 2. SW 0xDEADBEEF to 0x1C, then LW 0x1C
    txn(4'b1010, 32'h1C, 32'hDEADBEEF, lat, nrd, nwr, raddr, waddr, wdat, rdata, err, both);
    chk("sw_lat", lat, 2);
    chk("sw_nrd", nrd, 0);
    chk("sw_nwr", nwr, 1);
    chk("sw_waddr", waddr, 32'h7);
    chk("sw_wdat", wdat, 32'hDEADBEEF);
    chk("sw_rdata", rdata, 32'h0);
    txn(4'b0010, 32'h1C, 32'h0, lat, nrd, nwr, raddr, waddr, wdat, rdata, err, both);
    chk("lw_after_sw", rdata, 32'hDEADBEEF);

    // 3. SB 0x80 to 0x1D, then LB / LBU
    txn(4'b1000, 32'h1D, 32'h0000_0080, lat, nrd, nwr, raddr, waddr, wdat, rdata, err, both);
    chk("sb_lat", lat, 3);
    chk("sb_nrd", nrd, 1);
    chk("sb_nwr", nwr, 1);
    chk("sb_both", {31'h0, both}, 32'h0);
    chk("sb_wdat", wdat, 32'hDEAD80EF);
    chk("sb_mem", dmem[7], 32'hDEAD80EF);
    txn(4'b0000, 32'h1D, 32'h0, lat, nrd, nwr, raddr, waddr, wdat, rdata, err, both);
    chk("lb_rdata", rdata, 32'hFFFFFF80);
    txn(4'b0100, 32'h1D, 32'h0, lat, nrd, nwr, raddr, waddr, wdat, rdata, err, both);
    chk("lbu_rdata", rdata, 32'h00000080);
    txn(4'b0001, 32'h1E, 32'h0, lat, nrd, nwr, raddr, waddr, wdat, rdata, err, both);
    chk("lh_rdata", rdata, 32'hFFFFDEAD);
    txn(4'b0101, 32'h1E, 32'h0, lat, nrd, nwr, raddr, waddr, wdat, rdata, err, both);
    chk("lhu_rdata", rdata, 32'h0000DEAD);
    txn(4'b1001, 32'h22, 32'hAAAA_1234, lat, nrd, nwr, raddr, waddr, wdat, rdata, err, both);
    chk("sh_wdat", wdat, 32'h12340008);
    chk("sh_lat", lat, 3);

    // 4. error cases
    txn(4'b0001, 32'h1B, 32'h0, lat, nrd, nwr, raddr, waddr, wdat, rdata, err, both);
    chk("lh_mis_err", {31'h0, err}, 32'h1);
    chk("lh_mis_lat", lat, 1);
    chk("lh_mis_strobes", nrd + nwr, 0);
    chk("lh_mis_rdata", rdata, 32'h0);
    txn(4'b1010, 32'h400, 32'h12345678, lat, nrd, nwr, raddr, waddr, wdat, rdata, err, both);
    chk("sw_range_err", {31'h0, err}, 32'h1);
    chk("sw_range_lat", lat, 1);
    chk("sw_range_strobes", nrd + nwr, 0);
    txn(4'b0011, 32'h20, 32'h0, lat, nrd, nwr, raddr, waddr, wdat, rdata, err, both);
    chk("size11_err", {31'h0, err}, 32'h1);

    // 5. response backpressure
    req_valid = 1'b1; req_op = 4'b0010; req_addr = 32'h18; req_wdata = 32'h0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp_resp_valid", {31'h0, resp_valid}, 32'h1);
    hold_rdata = resp_rdata;
    chk("bp_rdata", hold_rdata, 32'h6);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", {31'h0, resp_valid}, 32'h1);
      chk("bp_hold_rdata", resp_rdata, 32'h6);
      chk("bp_req_ready", {31'h0, req_ready}, 32'h0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("bp_idle_ready", {31'h0, req_ready}, 32'h1);
    chk("bp_idle_valid", {31'h0, resp_valid}, 32'h0);
    txn(4'b0010, 32'h28, 32'h0, lat, nrd, nwr, raddr, waddr, wdat, rdata, err, both);
    chk("bp_next_rdata", rdata, 32'hA);

    // 6. reset during WRITE
    req_valid = 1'b1; req_op = 4'b1010; req_addr = 32'h24; req_wdata = 32'h55555555;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst_in_write", {31'h0, mem_memwrite}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("rst_write_drop", {31'h0, mem_memwrite}, 32'h0);
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_mem_addr", mem_addr, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_mem_kept", dmem[9], 32'h9);
    chk("rst_after_ready", {31'h0, req_ready}, 32'h1);
    txn(4'b0010, 32'h24, 32'h0, lat, nrd, nwr, raddr, waddr, wdat, rdata, err, both);
    chk("rst_reload", rdata, 32'h9);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
